// File: rtl/mul_seq_ctrl.sv
// Sequencer for a shift-add multiplier datapath: LOAD, then WIDTH CHECK/SHIFT
// iterations, then a one-cycle DONE. pd_write/alu_add are Mealy on mpr_lsb.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; all strobes low
// S_LOAD  | load operands, clear product register
// S_CHECK | conditionally add multiplicand into product-high (mpr_lsb)
// S_SHIFT | shift product and multiplier right; advance or finish
// S_DONE  | one-cycle done pulse, product valid in datapath
module mul_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          start,
  input  logic          abort,
  input  logic          mpr_lsb,
  output logic          ld,
  output logic          pd_write,
  output logic          pd_shift,
  output logic          mpr_shift,
  output logic          alu_add,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld_q, shift_q, busy_q, done_q;

  // abort is only honoured in the working states; IDLE and DONE ignore it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = abort ? S_IDLE : S_CHECK;
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CHECK;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore strobes are registered from the next state so they align with state_q
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= (state_d == S_LOAD);
      shift_q <= (state_d == S_SHIFT);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign ld        = ld_q;
  assign pd_shift  = shift_q;
  assign mpr_shift = shift_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cnt       = cnt_q;
  assign pd_write  = (state_q == S_CHECK) & mpr_lsb;
  assign alu_add   = (state_q == S_CHECK) & mpr_lsb;

endmodule
